wb_master_port: RTL

- Single-outstanding Wishbone pipelined initiator (master); the other end of the bus from the peripheral responders (GPIO, timers, UART).
- Converts a simple valid/ready command interface into one Wishbone transaction at a time.
- Handles `stall`, `ack` and `err`, and returns read data and status on a response strobe.
- Used by debug/DMA-style agents and by benches to drive responder blocks.

---
 rtl/wb_master_port.sv | 91 +++++++++
 1 files changed

// File: rtl/wb_master_port.sv
// wb_master_port: single-outstanding Wishbone pipelined initiator with a valid/ready command port.
// Define WB_MASTER_TIMEOUT_EN to abort transactions that get no ack/err within TIMEOUT cycles.
module wb_master_port #(
    parameter int AW      = 28,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            rsp_timeout,
    output logic            wb_cyc,
    output logic            wb_stb,
    output logic            wb_we,
    output logic [AW-1:0]   wb_adr,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack,
    input  logic            wb_err,
    input  logic            wb_stall
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_nxt;
    logic accept, done, expire, stb_taken;

    if (DW % 8 != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("wb_master_port: illegal DW or TIMEOUT");
    end

    assign cmd_ready = (state == IDLE) & ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign done      = (state != IDLE) & (wb_ack | wb_err);
    assign stb_taken = (state == REQ) & ~wb_stall;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk)
        cnt <= (rst || state == IDLE) ? '0 : cnt + 16'd1;
    // a real completion in the expiry cycle wins over the timeout
    assign expire = (state != IDLE) & ~done & (cnt == 16'(TIMEOUT));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    always_comb
        state_nxt = (state == IDLE) ? (accept ? REQ : IDLE) :
                    (done | expire) ? IDLE :
                    stb_taken       ? WAIT : state;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            wb_we       <= 1'b0;
            wb_adr      <= '0;
            wb_dat_o    <= '0;
            wb_sel      <= '0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            wb_cyc    <= accept | (wb_cyc & ~done & ~expire);
            wb_stb    <= accept | (wb_stb & ~done & ~expire & ~stb_taken);
            rsp_valid <= done | expire;
            if (accept) begin
                wb_we    <= cmd_we;
                wb_adr   <= cmd_adr;
                wb_dat_o <= cmd_dat;
                wb_sel   <= cmd_sel;
            end
            if (done | expire) begin
                rsp_dat     <= done ? wb_dat_i : '0;
                rsp_err     <= ~done | wb_err;
                rsp_timeout <= expire;
            end
        end
    end
endmodule
